jtag_host_sequencer: RTL and testbench

- Host-side driver that sits directly upstream of the JTAG TAP block and runs on the same TCK.
- Turns command words into TMS/TDI bit sequences: IR scans, DR scans and test-logic resets.
- Samples TDO during shifts and returns the captured bits as a response word.
- Used by the ripple-adder DFT bench and by any on-chip test master that drives the TAP.

---
 rtl/jtag_host_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_jtag_host_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_host_sequencer.sv
// Host-side JTAG sequencer: turns IR/DR scan and TAP-reset commands into TMS/TDI
// streams on the falling edge of TCK and collects TDO into a response word.
module jtag_host_sequencer #(
    parameter int MAX_LEN         = 64,
    parameter int LEN_W           = 7,
    parameter int IR_RESET_CYCLES = 5
) (
    input  logic               TCK,
    input  logic               Reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               TMS,
    output logic               TDI,
    input  logic               TDO,
    output logic               rsp_valid,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               busy
);

    typedef enum logic [2:0] {
        S_RST_HI,
        S_RST_LO,
        S_IDLE,
        S_PRE,
        S_SHIFT,
        S_UPDATE,
        S_RTI,
        S_DONE
    } state_t;

    localparam logic [LEN_W-1:0] LP_MAX_LEN = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LP_RST_CYC = LEN_W'(IR_RESET_CYCLES);
    localparam logic [LEN_W-1:0] LP_PRE_DR  = LEN_W'(2);
    localparam logic [LEN_W-1:0] LP_PRE_IR  = LEN_W'(3);

    state_t               r_state;
    logic [LEN_W-1:0]     r_cnt;
    logic                 r_is_ir;
    logic                 r_rst_op;
    logic [LEN_W-1:0]     r_len_m1;
    logic [MAX_LEN-1:0]   r_sdata;
    logic [MAX_LEN-1:0]   r_rsp;
    logic                 r_tms;
    logic                 r_tdi;
    logic                 r_rsp_valid;
    logic                 r_cmd_ready;
    logic                 r_busy;
    logic                 r_tdo_smp;

    state_t               w_state_n;
    logic [LEN_W-1:0]     w_cnt_n;
    logic                 w_is_ir_n;
    logic                 w_rst_op_n;
    logic [LEN_W-1:0]     w_len_m1_n;
    logic [MAX_LEN-1:0]   w_sdata_n;
    logic [MAX_LEN-1:0]   w_rsp_n;
    logic                 w_tms_n;
    logic                 w_tdi_n;
    logic [LEN_W-1:0]     w_len_eff;
    logic                 w_accept;

    assign w_accept  = cmd_valid && r_cmd_ready;
    assign w_len_eff = ((cmd_len == '0) || (cmd_len > LP_MAX_LEN)) ? LP_MAX_LEN : cmd_len;

    // Next-state process: also advances the TDI shifter and the capture word.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path infers a latch.
        w_state_n  = r_state;
        w_cnt_n    = r_cnt;
        w_is_ir_n  = r_is_ir;
        w_rst_op_n = r_rst_op;
        w_len_m1_n = r_len_m1;
        w_sdata_n  = r_sdata;
        w_rsp_n    = r_rsp;
        w_tdi_n    = 1'b0;

        case (r_state)
            S_RST_HI: begin
                if (r_cnt >= LP_RST_CYC) begin
                    w_state_n = S_RST_LO;
                    w_cnt_n   = '0;
                end else begin
                    w_cnt_n = r_cnt + LEN_W'(1);
                end
            end
            S_RST_LO: begin
                w_state_n = r_rst_op ? S_DONE : S_IDLE;
            end
            S_IDLE: begin
                if (w_accept) begin
                    if (cmd_op[1]) begin
                        // The accept edge already drives the first TMS=1 of the replay.
                        w_state_n  = S_RST_HI;
                        w_cnt_n    = LEN_W'(1);
                        w_rst_op_n = 1'b1;
                    end else begin
                        w_state_n  = S_PRE;
                        w_cnt_n    = '0;
                        w_is_ir_n  = cmd_op[0];
                        w_len_m1_n = w_len_eff - LEN_W'(1);
                        w_sdata_n  = cmd_data;
                        w_rsp_n    = '0;
                        w_rst_op_n = 1'b0;
                    end
                end
            end
            S_PRE: begin
                if (r_cnt == (r_is_ir ? LP_PRE_IR : LP_PRE_DR)) begin
                    w_state_n = S_SHIFT;
                    w_cnt_n   = '0;
                    w_tdi_n   = r_sdata[0];
                    w_sdata_n = r_sdata >> 1;
                end else begin
                    w_cnt_n = r_cnt + LEN_W'(1);
                end
            end
            S_SHIFT: begin
                // Bit k is committed at the edge closing shift period k.
                for (int i = 0; i < MAX_LEN; i++) begin
                    if (r_cnt == LEN_W'(i)) begin
                        w_rsp_n[i] = r_tdo_smp;
                    end
                end
                if (r_cnt == r_len_m1) begin
                    w_state_n = S_UPDATE;
                    w_cnt_n   = '0;
                end else begin
                    w_cnt_n   = r_cnt + LEN_W'(1);
                    w_tdi_n   = r_sdata[0];
                    w_sdata_n = r_sdata >> 1;
                end
            end
            S_UPDATE: w_state_n = S_RTI;
            S_RTI:    w_state_n = S_DONE;
            S_DONE: begin
                w_state_n  = S_IDLE;
                w_rst_op_n = 1'b0;
            end
            default: begin
                w_state_n = S_RST_HI;
                w_cnt_n   = '0;
            end
        endcase
    end

    // TMS for the period that the upcoming state occupies.
    always_comb begin
        w_tms_n = 1'b0;
        case (w_state_n)
            S_RST_HI: w_tms_n = 1'b1;
            S_PRE:    w_tms_n = (w_cnt_n == '0) || (w_is_ir_n && (w_cnt_n == LEN_W'(1)));
            S_SHIFT:  w_tms_n = (w_cnt_n == w_len_m1_n);
            S_UPDATE: w_tms_n = 1'b1;
            default:  w_tms_n = 1'b0;
        endcase
    end

    // All state and pin drivers move on the falling edge so the TAP sees stable levels at its rising edge.
    always_ff @(negedge TCK or posedge Reset) begin
        if (Reset) begin
            // NOTE: sequential state uses non-blocking assignments only.
            r_state     <= S_RST_HI;
            r_cnt       <= '0;
            r_is_ir     <= 1'b0;
            r_rst_op    <= 1'b0;
            r_len_m1    <= '0;
            r_sdata     <= '0;
            r_rsp       <= '0;
            r_tms       <= 1'b1;
            r_tdi       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
        end else begin
            r_state     <= w_state_n;
            r_cnt       <= w_cnt_n;
            r_is_ir     <= w_is_ir_n;
            r_rst_op    <= w_rst_op_n;
            r_len_m1    <= w_len_m1_n;
            r_sdata     <= w_sdata_n;
            r_rsp       <= w_rsp_n;
            r_tms       <= w_tms_n;
            r_tdi       <= w_tdi_n;
            r_rsp_valid <= (w_state_n == S_DONE);
            r_cmd_ready <= (w_state_n == S_IDLE);
            r_busy      <= (w_state_n != S_IDLE);
        end
    end

    // TDO is valid from the TAP at the rising edge inside each period.
    always_ff @(posedge TCK or posedge Reset) begin
        if (Reset) begin
            r_tdo_smp <= 1'b0;
        end else begin
            r_tdo_smp <= TDO;
        end
    end

    assign TMS       = r_tms;
    assign TDI       = r_tdi;
    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp;
    assign busy      = r_busy;

endmodule

// File: tb/tb_jtag_host_sequencer.sv
// Scoreboard bench for jtag_host_sequencer: random commands, random TDO stream,
// expected pin streams and responses computed from the command rules.
module tb_jtag_host_sequencer;

    localparam int MAX_LEN = 64;
    localparam int LEN_W   = 7;
    localparam int RST_CYC = 5;
    localparam int NLOG    = 8192;

    typedef struct {
        int           e0;
        int           rsp_j;
        logic [127:0] tms;
        logic [127:0] tdi;
        logic [63:0]  rsp;
    } exp_t;

    logic               TCK;
    logic               Reset;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_op;
    logic [LEN_W-1:0]   cmd_len;
    logic [MAX_LEN-1:0] cmd_data;
    logic               TMS;
    logic               TDI;
    logic               TDO;
    logic               rsp_valid;
    logic [MAX_LEN-1:0] rsp_data;
    logic               busy;

    jtag_host_sequencer #(
        .MAX_LEN(MAX_LEN),
        .LEN_W(LEN_W),
        .IR_RESET_CYCLES(RST_CYC)
    ) dut (
        .TCK(TCK),
        .Reset(Reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_len(cmd_len),
        .cmd_data(cmd_data),
        .TMS(TMS),
        .TDI(TDI),
        .TDO(TDO),
        .rsp_valid(rsp_valid),
        .rsp_data(rsp_data),
        .busy(busy)
    );

    int          per_n = 0;
    logic        tdo_log [NLOG];
    exp_t        q[$];
    logic [63:0] last_rsp = '0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          idle_err = 0;
    bit          mon_en = 0;
    bit          err_tms = 0;
    bit          err_tdi = 0;
    bit          err_ctl = 0;

    initial TCK = 1'b1;
    always #5 TCK = ~TCK;

    // Period n is the TCK period that begins with falling edge n.
    initial forever begin
        @(negedge TCK);
        per_n++;
    end

    initial begin
        TDO = 1'b0;
        forever begin
            @(negedge TCK);
            #2 TDO = tdo_log[per_n % NLOG];
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic exp_t build_exp(input logic [1:0] op, input logic [6:0] len,
                                       input logic [63:0] data, input int e0);
        exp_t e;
        int   l;
        int   p;
        e.e0  = e0;
        e.tms = '0;
        e.tdi = '0;
        l = (len == 0 || len > MAX_LEN) ? MAX_LEN : int'(len);
        if (op[1]) begin
            for (int j = 0; j < RST_CYC; j++) e.tms[j] = 1'b1;
            e.rsp_j = RST_CYC + 1;
            e.rsp   = last_rsp;
        end else begin
            p = op[0] ? 4 : 3;
            e.tms[0] = 1'b1;
            if (op[0]) e.tms[1] = 1'b1;
            e.tms[p + l - 1] = 1'b1;
            e.tms[p + l]     = 1'b1;
            e.rsp = '0;
            for (int k = 0; k < l; k++) begin
                e.tdi[p + k] = data[k];
                e.rsp[k]     = tdo_log[(e0 + p + k) % NLOG];
            end
            e.rsp_j  = p + l + 2;
            last_rsp = e.rsp;
        end
        return e;
    endfunction

    // Monitor: compares every period of the active command and scores the response.
    always @(posedge TCK) begin
        int j;
        if (mon_en) begin
            if (q.size() > 0 && per_n >= q[0].e0) begin
                j = per_n - q[0].e0;
                if (TMS !== q[0].tms[j]) err_tms = 1;
                if (TDI !== q[0].tdi[j]) err_tdi = 1;
                if (cmd_ready !== 1'b0 || busy !== 1'b1) err_ctl = 1;
                if (rsp_valid === 1'b1 || j >= q[0].rsp_j) begin
                    check("rsp_latency", j, q[0].rsp_j);
                    check("rsp_valid", rsp_valid, 1'b1);
                    check("rsp_data", rsp_data, q[0].rsp);
                    check("tms_stream", err_tms, 1'b0);
                    check("tdi_stream", err_tdi, 1'b0);
                    check("busy_ready", err_ctl, 1'b0);
                    void'(q.pop_front());
                    err_tms = 0;
                    err_tdi = 0;
                    err_ctl = 0;
                end
            end else begin
                if (TMS !== 1'b0 || TDI !== 1'b0 || busy !== 1'b0 ||
                    cmd_ready !== 1'b1 || rsp_valid !== 1'b0) idle_err++;
            end
        end
    end

    task automatic power_on_seq(input string tag);
        logic [6:0] tms_s;
        logic [6:0] rdy_s;
        logic [6:0] vld_s;
        @(posedge TCK);
        #1 Reset = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(posedge TCK);
            tms_s[i] = TMS;
            rdy_s[i] = cmd_ready;
            vld_s[i] = rsp_valid;
        end
        check({tag, "_tms"}, tms_s, 7'b0011111);
        check({tag, "_ready"}, rdy_s, 7'b1000000);
        check({tag, "_rsp_valid"}, vld_s, 7'b0000000);
    endtask

    task automatic issue(input logic [1:0] op, input logic [6:0] len, input logic [63:0] data,
                         input bit hold, output int e0);
        int guard;
        bit done;
        @(negedge TCK);
        #1;
        cmd_op    = op;
        cmd_len   = len;
        cmd_data  = data;
        cmd_valid = 1'b1;
        guard = 0;
        done  = 0;
        e0    = -1;
        while (!done && guard < 300) begin
            @(posedge TCK);
            guard++;
            if (cmd_ready === 1'b1) begin
                e0 = per_n + 1;
                q.push_back(build_exp(op, len, data, e0));
                done = 1;
            end
        end
        if (!done) begin
            check("accept_timeout", cmd_ready, 1'b1);
            cmd_valid = 1'b0;
        end else begin
            @(negedge TCK);
            #1;
            if (hold) begin
                // Valid stays high through the whole command; only one accept may follow.
                guard = 0;
                while (rsp_valid !== 1'b1 && guard < 300) begin
                    @(posedge TCK);
                    guard++;
                end
                #1;
            end
            cmd_valid = 1'b0;
            cmd_data  = {$urandom, $urandom};
        end
    endtask

    initial begin
        int e0;
        int guard;
        logic [1:0] op;
        logic [6:0] len;
        for (int i = 0; i < NLOG; i++) tdo_log[i] = 1'($urandom);
        Reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_len   = '0;
        cmd_data  = '0;

        #12;
        check("reset_pins", {TMS, TDI, cmd_ready, rsp_valid, busy}, 5'b10001);
        check("reset_rsp_data", rsp_data, 64'h0);
        power_on_seq("power_on");
        mon_en = 1;

        issue(2'b01, 7'd2,   64'h2, 0, e0);
        issue(2'b00, 7'd1,   64'h1, 0, e0);
        issue(2'b00, 7'd51,  64'h5_5555_5555_5555, 0, e0);
        issue(2'b00, 7'd8,   64'hA5, 0, e0);
        issue(2'b00, 7'd0,   64'hDEAD_BEEF_0123_4567, 0, e0);
        issue(2'b01, 7'd100, 64'hFFFF_0000_AAAA_5555, 0, e0);
        issue(2'b00, 7'd64,  64'h8000_0000_0000_0001, 0, e0);
        issue(2'b11, 7'd5,   64'h1234, 0, e0);
        issue(2'b10, 7'd9,   64'h0, 1, e0);
        issue(2'b00, 7'd3,   64'h5, 0, e0);

        for (int n = 0; n < 40; n++) begin
            op  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
            len = ($urandom_range(0, 5) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(1, 64));
            repeat ($urandom_range(0, 3)) @(negedge TCK);
            issue(op, len, {$urandom, $urandom}, ($urandom_range(0, 3) == 0), e0);
        end

        // Reset during shift bit 10 of a 51-bit DR scan.
        issue(2'b00, 7'd51, {$urandom, $urandom}, 0, e0);
        guard = 0;
        while (per_n < e0 + 13 && guard < 200) begin
            @(posedge TCK);
            guard++;
        end
        #1;
        mon_en = 0;
        Reset  = 1'b1;
        #1;
        check("midscan_pins", {TMS, TDI, cmd_ready, rsp_valid, busy}, 5'b10001);
        check("midscan_rsp_data", rsp_data, 64'h0);
        q.delete();
        err_tms  = 0;
        err_tdi  = 0;
        err_ctl  = 0;
        last_rsp = '0;
        power_on_seq("midscan_replay");
        mon_en = 1;

        issue(2'b10, 7'd0,  64'h0, 0, e0);
        issue(2'b01, 7'd7,  {$urandom, $urandom}, 0, e0);
        issue(2'b10, 7'd0,  64'h0, 1, e0);

        guard = 0;
        while (q.size() > 0 && guard < 200) begin
            @(posedge TCK);
            guard++;
        end
        check("queue_drained", q.size(), 0);
        repeat (3) @(posedge TCK);
        check("idle_state", idle_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
